// File: rtl/hazard_unit_if.sv
// hazard_unit_if: ID-stage instruction fields in, stall/forwarding decisions out.
// Latency: none, this is only a signal bundle.
// Backpressure: harzard is the only stall indication carried back to the ID side.
interface hazard_unit_if #(
   parameter int REG_W = 5
);
   logic             id_valid;
   logic [5:0]       id_op;
   logic [5:0]       id_funct;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_rs_used;
   logic             id_rt_used;
   logic [REG_W-1:0] id_dest;
   logic             id_wb_en;
   logic             id_mem_r;
   logic             harzard;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             fwd_br_a;
   logic             fwd_br_b;
   logic             drain_done;

   // ID stage side: presents the decoded instruction, receives decisions
   modport master (
      output id_valid, id_op, id_funct, id_rs, id_rt, id_rs_used, id_rt_used,
             id_dest, id_wb_en, id_mem_r,
      input  harzard, fwd_a_sel, fwd_b_sel, fwd_br_a, fwd_br_b, drain_done
   );

   // Hazard unit side
   modport slave (
      input  id_valid, id_op, id_funct, id_rs, id_rt, id_rs_used, id_rt_used,
             id_dest, id_wb_en, id_mem_r,
      output harzard, fwd_a_sel, fwd_b_sel, fwd_br_a, fwd_br_b, drain_done
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: in-flight destination scoreboard, load-use/branch stalls, operand forwarding, terminate drain.
// Latency: harzard and fwd_br_* combinational; fwd_a_sel/fwd_b_sel registered, valid while the instruction sits in EX.
// Backpressure: harzard freezes PC and IF/ID and bubbles EX; held high from terminate until reset.
// Option macro BRANCH_FWD_EN: forward ALU results from MEM to the ID branch comparator instead of stalling.
module hazard_unit #(
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave bus
);
   localparam int         CNT_W    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] OP_TERM  = 6'h3F;
   localparam logic [5:0] FN_TERM  = 6'h3F;

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   // Only EX and MEM producers matter: a WB producer is written to the
   // register file before ID reads it, so it never stalls or forwards.
   logic             r_ex_v, r_ex_ld, r_mem_v;
   logic [REG_W-1:0] r_ex_dest, r_mem_dest;
`ifdef BRANCH_FWD_EN
   logic             r_mem_ld;
`endif
   logic [1:0]       r_fwd_a, r_fwd_b;

   logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
   logic w_is_br, w_load_use, w_mem_blk, w_br_stall;
   logic w_harzard, w_issue, w_term, w_adv;
   logic [1:0] w_sel_a, w_sel_b;

   assign w_rs_ex  = r_ex_v  && (r_ex_dest  == bus.id_rs) && (bus.id_rs != '0) && bus.id_rs_used;
   assign w_rt_ex  = r_ex_v  && (r_ex_dest  == bus.id_rt) && (bus.id_rt != '0) && bus.id_rt_used;
   assign w_rs_mem = r_mem_v && (r_mem_dest == bus.id_rs) && (bus.id_rs != '0) && bus.id_rs_used;
   assign w_rt_mem = r_mem_v && (r_mem_dest == bus.id_rt) && (bus.id_rt != '0) && bus.id_rt_used;

   assign w_is_br    = (bus.id_op == OP_BEQ) || (bus.id_op == OP_BNE) ||
                       ((bus.id_op == OP_RTYPE) && (bus.id_funct == FN_JR));
   assign w_load_use = (w_rs_ex || w_rt_ex) && r_ex_ld;
`ifdef BRANCH_FWD_EN
   // An ALU result in MEM can be forwarded; only a load there must wait.
   assign w_mem_blk  = (w_rs_mem || w_rt_mem) && r_mem_ld;
`else
   assign w_mem_blk  = w_rs_mem || w_rt_mem;
`endif
   assign w_br_stall = w_is_br && (w_rs_ex || w_rt_ex || w_mem_blk);
   assign w_harzard  = (bus.id_valid && (w_load_use || w_br_stall)) || (r_state != S_RUN);
   assign w_issue    = bus.id_valid && !w_harzard;
   assign w_term     = w_issue && (bus.id_op == OP_TERM) && (bus.id_funct == FN_TERM);
   // The terminate instruction itself goes down the pipe as a bubble.
   assign w_adv      = w_issue && !w_term;

   // EX producer wins over MEM: it holds the younger value.
   assign w_sel_a = w_rs_ex ? 2'd1 : (w_rs_mem ? 2'd2 : 2'd0);
   assign w_sel_b = w_rt_ex ? 2'd1 : (w_rt_mem ? 2'd2 : 2'd0);

   assign bus.harzard    = w_harzard;
   assign bus.fwd_a_sel  = r_fwd_a;
   assign bus.fwd_b_sel  = r_fwd_b;
   assign bus.drain_done = (r_state == S_DONE);
`ifdef BRANCH_FWD_EN
   assign bus.fwd_br_a   = w_rs_mem && !r_mem_ld && !w_harzard;
   assign bus.fwd_br_b   = w_rt_mem && !r_mem_ld && !w_harzard;
`else
   assign bus.fwd_br_a   = 1'b0;
   assign bus.fwd_br_b   = 1'b0;
`endif

   // Advance the scoreboard and register the EX operand selects
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_v     <= 1'b0;
         r_ex_ld    <= 1'b0;
         r_ex_dest  <= '0;
         r_mem_v    <= 1'b0;
         r_mem_dest <= '0;
`ifdef BRANCH_FWD_EN
         r_mem_ld   <= 1'b0;
`endif
         r_fwd_a    <= 2'd0;
         r_fwd_b    <= 2'd0;
      end else begin
         r_mem_v    <= r_ex_v;
         r_mem_dest <= r_ex_dest;
`ifdef BRANCH_FWD_EN
         r_mem_ld   <= r_ex_ld;
`endif
         r_ex_v     <= w_adv && bus.id_wb_en && (bus.id_dest != '0);
         r_ex_ld    <= w_adv && bus.id_mem_r;
         r_ex_dest  <= bus.id_dest;
         r_fwd_a    <= w_adv ? w_sel_a : 2'd0;
         r_fwd_b    <= w_adv ? w_sel_b : 2'd0;
      end
   end

   // Drain FSM state and countdown register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Drain FSM next state: RUN -> DRAIN on terminate -> DONE when the count expires
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_RUN: begin
            if (w_term) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
            end
         end
         S_DRAIN: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_RUN;
      endcase
   end
endmodule
